// File: rtl/operand_feeder_if.sv
// Operand feeder bus: array-controller strobes, lane write ports and lane outputs.
interface operand_feeder_if #(
  parameter int unsigned N  = 2,
  parameter int unsigned M  = 2,
  parameter int unsigned DW = 8
);
  localparam int unsigned ALW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BLW = (M > 1) ? $clog2(M) : 1;

  logic [N-1:0]    A_start_en;
  logic [M-1:0]    B_start_en;
  logic            load;
  logic            a_wr_en;
  logic [ALW-1:0]  a_wr_lane;
  logic [DW-1:0]   a_wr_data;
  logic            b_wr_en;
  logic [BLW-1:0]  b_wr_lane;
  logic [DW-1:0]   b_wr_data;
  logic [N*DW-1:0] a_out;
  logic [N-1:0]    a_valid;
  logic [M*DW-1:0] b_out;
  logic [M-1:0]    b_valid;
  logic            finished;
  logic            overflow;

  // Controller / producer side
  modport master (
    output A_start_en, B_start_en, load,
    output a_wr_en, a_wr_lane, a_wr_data,
    output b_wr_en, b_wr_lane, b_wr_data,
    input  a_out, a_valid, b_out, b_valid, finished, overflow
  );

  // Feeder side
  modport slave (
    input  A_start_en, B_start_en, load,
    input  a_wr_en, a_wr_lane, a_wr_data,
    input  b_wr_en, b_wr_lane, b_wr_data,
    output a_out, a_valid, b_out, b_valid, finished, overflow
  );
endinterface

// File: rtl/operand_feeder.sv
// Operand feeder: per-lane FIFOs for the A rows and B columns of a systolic array.
// On each load strobe, enabled non-empty lanes pop one operand, shown registered the
// following cycle; disabled or empty lanes emit zero padding.
module operand_feeder #(
  parameter int unsigned N  = 2,
  parameter int unsigned M  = 2,
  parameter int unsigned DW = 8,
  parameter int unsigned K  = 4
) (
  input  logic              clk,
  input  logic              rst,
  operand_feeder_if.slave   bus
);
  localparam int unsigned PW = $clog2(K);
  localparam int unsigned CW = $clog2(K + 1);

  logic [N-1:0] a_pop, a_acc, a_ovf, a_empty;
  logic [M-1:0] b_pop, b_acc, b_ovf, b_empty;

  logic overflow_q, overflow_d;
  logic armed_q, armed_d;
  logic finished_q, finished_d;

  for (genvar i = 0; i < N; i++) begin : g_a_lane
    logic [DW-1:0] mem_q [K];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] out_q, out_d;
    logic          valid_q, valid_d;
    logic          wr_hit;

    // Out-of-range lane indices never match, so they are silently ignored
    assign wr_hit     = bus.a_wr_en && (32'(bus.a_wr_lane) == i);
    assign a_pop[i]   = bus.load && bus.A_start_en[i] && (cnt_q != '0);
    // A full lane still accepts a write when it pops in the same cycle
    assign a_acc[i]   = wr_hit && ((cnt_q != CW'(K)) || a_pop[i]);
    assign a_ovf[i]   = wr_hit && (cnt_q == CW'(K)) && !a_pop[i];
    assign a_empty[i] = (cnt_d == '0);

    // Pointer, occupancy and output next-state
    always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      out_d    = '0;
      valid_d  = 1'b0;
      if (a_pop[i]) begin
        out_d    = mem_q[rd_ptr_q];
        valid_d  = 1'b1;
        rd_ptr_d = (rd_ptr_q == PW'(K - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      if (a_acc[i]) begin
        wr_ptr_d = (wr_ptr_q == PW'(K - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      case ({a_acc[i], a_pop[i]})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // Operand storage, not reset
    always_ff @(posedge clk) begin
      if (a_acc[i]) mem_q[wr_ptr_q] <= bus.a_wr_data;
    end

    // Lane state and registered output
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
        out_q    <= '0;
        valid_q  <= 1'b0;
      end else begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        cnt_q    <= cnt_d;
        out_q    <= out_d;
        valid_q  <= valid_d;
      end
    end

    assign bus.a_out[i*DW +: DW] = out_q;
    assign bus.a_valid[i]        = valid_q;
  end

  for (genvar j = 0; j < M; j++) begin : g_b_lane
    logic [DW-1:0] mem_q [K];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] out_q, out_d;
    logic          valid_q, valid_d;
    logic          wr_hit;

    assign wr_hit     = bus.b_wr_en && (32'(bus.b_wr_lane) == j);
    assign b_pop[j]   = bus.load && bus.B_start_en[j] && (cnt_q != '0);
    assign b_acc[j]   = wr_hit && ((cnt_q != CW'(K)) || b_pop[j]);
    assign b_ovf[j]   = wr_hit && (cnt_q == CW'(K)) && !b_pop[j];
    assign b_empty[j] = (cnt_d == '0);

    // Pointer, occupancy and output next-state
    always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      out_d    = '0;
      valid_d  = 1'b0;
      if (b_pop[j]) begin
        out_d    = mem_q[rd_ptr_q];
        valid_d  = 1'b1;
        rd_ptr_d = (rd_ptr_q == PW'(K - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      if (b_acc[j]) begin
        wr_ptr_d = (wr_ptr_q == PW'(K - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      case ({b_acc[j], b_pop[j]})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // Operand storage, not reset
    always_ff @(posedge clk) begin
      if (b_acc[j]) mem_q[wr_ptr_q] <= bus.b_wr_data;
    end

    // Lane state and registered output
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
        out_q    <= '0;
        valid_q  <= 1'b0;
      end else begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        cnt_q    <= cnt_d;
        out_q    <= out_d;
        valid_q  <= valid_d;
      end
    end

    assign bus.b_out[j*DW +: DW] = out_q;
    assign bus.b_valid[j]        = valid_q;
  end

  // Sticky overflow, armed tracking and drain-complete flag
  always_comb begin
    overflow_d = overflow_q | (|a_ovf) | (|b_ovf);
    armed_d    = armed_q;
    if ((|a_acc) || (|b_acc)) begin
      armed_d = 1'b0;
    end else if ((|a_pop) || (|b_pop)) begin
      armed_d = 1'b1;
    end
    finished_d = armed_d && (&a_empty) && (&b_empty);
  end

  // Global status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
      armed_q    <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      armed_q    <= armed_d;
      finished_q <= finished_d;
    end
  end

  assign bus.overflow = overflow_q;
  assign bus.finished = finished_q;
endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder with N=M=2, DW=8, K=4.
module tb_operand_feeder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  operand_feeder_if #(.N(2), .M(2), .DW(8)) bus ();

  operand_feeder #(.N(2), .M(2), .DW(8), .K(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.A_start_en = '0;
    bus.B_start_en = '0;
    bus.load       = 1'b0;
    bus.a_wr_en    = 1'b0;
    bus.a_wr_lane  = '0;
    bus.a_wr_data  = '0;
    bus.b_wr_en    = 1'b0;
    bus.b_wr_lane  = '0;
    bus.b_wr_data  = '0;
  endtask

  task automatic write_a(input logic lane, input logic [7:0] d);
    bus.a_wr_en = 1'b1; bus.a_wr_lane = lane; bus.a_wr_data = d;
    tick();
    bus.a_wr_en = 1'b0;
  endtask

  task automatic write_b(input logic lane, input logic [7:0] d);
    bus.b_wr_en = 1'b1; bus.b_wr_lane = lane; bus.b_wr_data = d;
    tick();
    bus.b_wr_en = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.a_out !== 16'h0) begin errors++; $display("FAIL reset_a_out got=%h exp=0000", bus.a_out); end
    checks++; if (bus.a_valid !== 2'b00) begin errors++; $display("FAIL reset_a_valid got=%b exp=00", bus.a_valid); end
    checks++; if (bus.b_out !== 16'h0) begin errors++; $display("FAIL reset_b_out got=%h exp=0000", bus.b_out); end
    checks++; if (bus.b_valid !== 2'b00) begin errors++; $display("FAIL reset_b_valid got=%b exp=00", bus.b_valid); end
    checks++; if (bus.finished !== 1'b0) begin errors++; $display("FAIL reset_finished got=%b exp=0", bus.finished); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    #20;
    rst = 1'b1;
    tick();
    checks++; if (bus.a_valid !== 2'b00 || bus.finished !== 1'b0) begin errors++;
      $display("FAIL reset_release got valid=%b fin=%b exp valid=00 fin=0", bus.a_valid, bus.finished); end
  endtask

  task automatic test_single_lane();
    write_a(1'b0, 8'd3);
    write_a(1'b0, 8'd5);
    bus.load = 1'b1; bus.A_start_en = 2'b01;
    tick();
    checks++; if (bus.a_out !== 16'h0003) begin errors++; $display("FAIL single_out0 got=%h exp=0003", bus.a_out); end
    checks++; if (bus.a_valid !== 2'b01) begin errors++; $display("FAIL single_valid0 got=%b exp=01", bus.a_valid); end
    tick();
    checks++; if (bus.a_out !== 16'h0005) begin errors++; $display("FAIL single_out1 got=%h exp=0005", bus.a_out); end
    checks++; if (bus.a_valid !== 2'b01) begin errors++; $display("FAIL single_valid1 got=%b exp=01", bus.a_valid); end
    checks++; if (bus.finished !== 1'b1) begin errors++; $display("FAIL single_finished got=%b exp=1", bus.finished); end
    idle_inputs();
    tick();
    checks++; if (bus.a_out !== 16'h0 || bus.a_valid !== 2'b00) begin errors++;
      $display("FAIL single_idle got out=%h valid=%b exp out=0000 valid=00", bus.a_out, bus.a_valid); end
  endtask

  task automatic test_no_enable();
    write_a(1'b0, 8'h77);
    checks++; if (bus.finished !== 1'b0) begin errors++; $display("FAIL write_clears_finished got=%b exp=0", bus.finished); end
    bus.load = 1'b1; bus.A_start_en = 2'b00;
    tick();
    checks++; if (bus.a_valid !== 2'b00 || bus.a_out !== 16'h0) begin errors++;
      $display("FAIL noen_pop got out=%h valid=%b exp out=0000 valid=00", bus.a_out, bus.a_valid); end
    bus.A_start_en = 2'b01;
    tick();
    checks++; if (bus.a_out !== 16'h0077 || bus.a_valid !== 2'b01) begin errors++;
      $display("FAIL noen_head got out=%h valid=%b exp out=0077 valid=01", bus.a_out, bus.a_valid); end
    idle_inputs();
    tick();
  endtask

  task automatic test_skew();
    logic [1:0]  en   [5];
    logic [15:0] eout [5];
    en   = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b10};
    eout = '{16'h000a, 16'h140b, 16'h150c, 16'h160d, 16'h1700};
    for (int k = 0; k < 4; k++) write_a(1'b0, 8'(8'h0a + k));
    for (int k = 0; k < 4; k++) write_a(1'b1, 8'(8'h14 + k));
    for (int s = 0; s < 5; s++) begin
      bus.load = 1'b1; bus.A_start_en = en[s];
      tick();
      checks++; if (bus.a_out !== eout[s] || bus.a_valid !== en[s]) begin errors++;
        $display("FAIL skew_step%0d got out=%h valid=%b exp out=%h valid=%b",
                 s, bus.a_out, bus.a_valid, eout[s], en[s]); end
    end
    idle_inputs();
    tick();
    checks++; if (bus.a_valid !== 2'b00 || bus.finished !== 1'b1) begin errors++;
      $display("FAIL skew_end got valid=%b fin=%b exp valid=00 fin=1", bus.a_valid, bus.finished); end
  endtask

  task automatic test_overflow();
    logic [15:0] eo;
    for (int k = 1; k <= 4; k++) write_a(1'b0, 8'(k));
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full got=%b exp=0", bus.overflow); end
    write_a(1'b0, 8'd5);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
    bus.load = 1'b1; bus.A_start_en = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      tick();
      eo = (k <= 4) ? 16'(k) : 16'h0;
      checks++; if (bus.a_out !== eo || bus.a_valid !== ((k <= 4) ? 2'b01 : 2'b00)) begin errors++;
        $display("FAIL ovf_drain%0d got out=%h valid=%b exp out=%h", k, bus.a_out, bus.a_valid, eo); end
    end
    idle_inputs();
    pulse_reset();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_after_reset got=%b exp=0", bus.overflow); end
    for (int k = 1; k <= 4; k++) write_a(1'b0, 8'(k));
    bus.a_wr_en = 1'b1; bus.a_wr_lane = 1'b0; bus.a_wr_data = 8'd5;
    bus.load = 1'b1; bus.A_start_en = 2'b01;
    tick();
    bus.a_wr_en = 1'b0;
    checks++; if (bus.a_out !== 16'h0001 || bus.overflow !== 1'b0) begin errors++;
      $display("FAIL ovf_pop_write got out=%h ovf=%b exp out=0001 ovf=0", bus.a_out, bus.overflow); end
    for (int k = 2; k <= 5; k++) begin
      tick();
      checks++; if (bus.a_out !== 16'(k) || bus.a_valid !== 2'b01) begin errors++;
        $display("FAIL ovf_accept%0d got out=%h valid=%b exp out=%h valid=01",
                 k, bus.a_out, bus.a_valid, 16'(k)); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_finish();
    logic [15:0] ea, eb;
    for (int k = 0; k < 4; k++) begin
      bus.a_wr_en = 1'b1; bus.a_wr_lane = 1'b0; bus.a_wr_data = 8'(8'h30 + k);
      bus.b_wr_en = 1'b1; bus.b_wr_lane = 1'b0; bus.b_wr_data = 8'(8'h40 + k);
      tick();
      bus.a_wr_lane = 1'b1; bus.a_wr_data = 8'(8'h38 + k);
      bus.b_wr_lane = 1'b1; bus.b_wr_data = 8'(8'h48 + k);
      tick();
    end
    idle_inputs();
    bus.load = 1'b1; bus.A_start_en = 2'b11; bus.B_start_en = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      ea = {8'(8'h38 + k), 8'(8'h30 + k)};
      eb = {8'(8'h48 + k), 8'(8'h40 + k)};
      checks++; if (bus.a_out !== ea || bus.b_out !== eb || bus.b_valid !== 2'b11) begin errors++;
        $display("FAIL finish_data%0d got a=%h b=%h bv=%b exp a=%h b=%h bv=11",
                 k, bus.a_out, bus.b_out, bus.b_valid, ea, eb); end
      checks++; if (bus.finished !== (k == 3)) begin errors++;
        $display("FAIL finish_flag%0d got=%b exp=%b", k, bus.finished, (k == 3)); end
    end
    idle_inputs();
    tick();
    checks++; if (bus.finished !== 1'b1) begin errors++; $display("FAIL finish_hold got=%b exp=1", bus.finished); end
    write_a(1'b1, 8'h99);
    checks++; if (bus.finished !== 1'b0) begin errors++; $display("FAIL finish_clear got=%b exp=0", bus.finished); end
    bus.load = 1'b1; bus.A_start_en = 2'b10;
    tick();
    checks++; if (bus.a_out !== 16'h9900 || bus.finished !== 1'b1) begin errors++;
      $display("FAIL finish_rearm got out=%h fin=%b exp out=9900 fin=1", bus.a_out, bus.finished); end
    idle_inputs();
    tick();
  endtask

  task automatic test_empty_pop_reset();
    bus.a_wr_en = 1'b1; bus.a_wr_lane = 1'b1; bus.a_wr_data = 8'd9;
    bus.load = 1'b1; bus.A_start_en = 2'b10;
    tick();
    bus.a_wr_en = 1'b0;
    checks++; if (bus.a_out !== 16'h0 || bus.a_valid !== 2'b00) begin errors++;
      $display("FAIL empty_nobypass got out=%h valid=%b exp out=0000 valid=00", bus.a_out, bus.a_valid); end
    tick();
    checks++; if (bus.a_out !== 16'h0900 || bus.a_valid !== 2'b10) begin errors++;
      $display("FAIL empty_stored got out=%h valid=%b exp out=0900 valid=10", bus.a_out, bus.a_valid); end
    idle_inputs();
    for (int k = 0; k < 5; k++) write_b(1'b0, 8'(8'h60 + k));
    write_a(1'b0, 8'h21);
    write_a(1'b0, 8'h22);
    bus.load = 1'b1; bus.A_start_en = 2'b01;
    tick();
    checks++; if (bus.a_out !== 16'h0021 || bus.overflow !== 1'b1) begin errors++;
      $display("FAIL middrain_pre got out=%h ovf=%b exp out=0021 ovf=1", bus.a_out, bus.overflow); end
    bus.A_start_en = 2'b11; bus.B_start_en = 2'b11;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.a_out !== 16'h0 || bus.a_valid !== 2'b00 || bus.b_valid !== 2'b00) begin errors++;
      $display("FAIL middrain_async_out got a=%h av=%b bv=%b exp 0000/00/00", bus.a_out, bus.a_valid, bus.b_valid); end
    checks++; if (bus.finished !== 1'b0 || bus.overflow !== 1'b0) begin errors++;
      $display("FAIL middrain_async_flags got fin=%b ovf=%b exp 0/0", bus.finished, bus.overflow); end
    #2;
    rst = 1'b1;
    tick();
    checks++; if (bus.a_valid !== 2'b00 || bus.b_valid !== 2'b00 || bus.finished !== 1'b0) begin errors++;
      $display("FAIL middrain_counts got av=%b bv=%b fin=%b exp 00/00/0", bus.a_valid, bus.b_valid, bus.finished); end
    idle_inputs();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_lane();
    test_no_enable();
    test_skew();
    test_overflow();
    test_finish();
    test_empty_pop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_feeder.md
OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning the number of A lanes (array rows).
REQ-002 The block SHALL have parameter M, default 2, meaning the number of B lanes (array columns).
REQ-003 The block SHALL have parameter DW, default 8, meaning the operand width in bits.
REQ-004 The block SHALL have parameter K, default 4, meaning the per-lane FIFO depth and inner dimension, with K >= 2.
REQ-005 The block SHALL have ports as follows:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- A_start_en  in  N  per-lane A enable from the array controller.
- B_start_en  in  M  per-lane B enable from the array controller.
- load  in  1  single-cycle advance strobe from the array controller.
- a_wr_en  in  1  A lane write strobe.
- a_wr_lane  in  clog2(N) (min 1)  target A lane.
- a_wr_data  in  DW  A operand.
- b_wr_en  in  1  B lane write strobe.
- b_wr_lane  in  clog2(M) (min 1)  target B lane.
- b_wr_data  in  DW  B operand.
- a_out  out  N*DW  A operands; lane i occupies bits [i*DW +: DW].
- a_valid  out  N  per-lane A valid.
- b_out  out  M*DW  B operands, packed the same way as a_out.
- b_valid  out  M  per-lane B valid.
- finished  out  1  all loaded operands drained.
- overflow  out  1  sticky write-to-full indicator.

Function
REQ-006 Each A lane and each B lane SHALL contain an independent FIFO of depth K, with occupancy count in the range 0..K and wrap-around read and write pointers.
REQ-007 A write with a_wr_en=1 SHALL push a_wr_data into lane a_wr_lane when that lane's count < K; B writes SHALL behave the same way.
REQ-008 A write to a full lane SHALL be dropped and SHALL set overflow=1, except when a pop on that same lane occurs in the same cycle, in which case the write SHALL be accepted.
REQ-009 A write with a lane index >= N (or >= M for B) SHALL be ignored and SHALL NOT set overflow.
REQ-010 In a cycle with load=1, every lane i with start_en[i]=1 and count>0 SHALL pop its head entry.
REQ-011 Pop latency SHALL be one cycle: in the cycle after the pop, out lane i SHALL show the popped data and valid[i]=1.
REQ-012 In every other case, including no load, start_en[i]=0, or an empty lane (zero padding for skew), out lane i SHALL be 0 and valid[i] SHALL be 0 in the following cycle.
REQ-013 valid SHALL never be high for more than one cycle per pop.
REQ-014 When a write and a pop hit the same lane in the same cycle, both SHALL take effect and the count SHALL be unchanged.
REQ-015 On an empty lane, a simultaneous write SHALL NOT bypass to the output: the output SHALL be zero with valid 0, and the written data SHALL be stored.
REQ-016 An internal armed flag SHALL be set by any successful pop and cleared by any accepted write; an accepted write SHALL take precedence over a simultaneous pop.
REQ-017 finished SHALL be registered and SHALL equal 1 exactly when armed=1 and all N+M lanes have count 0, updating one cycle after the causing event.
REQ-018 finished SHALL deassert one cycle after any accepted write.
REQ-019 The block SHALL NOT depend on the staggered pattern of start_en; any enable pattern SHALL be legal.
REQ-020 load=1 with all enables 0 SHALL pop nothing.

Reset
REQ-021 While rst=0, asynchronously and independent of clk, the block SHALL clear all counts and pointers, armed, overflow and finished.
REQ-022 While rst=0, a_out, a_valid, b_out and b_valid SHALL be 0.
REQ-023 FIFO storage contents SHALL NOT be required to reset.
REQ-024 A reset asserted mid-drain SHALL discard all queued operands, and after release the block SHALL behave as freshly reset.
REQ-025 Deassertion of rst SHALL take effect at the next rising edge of clk, with no pop or write occurring in the release cycle unless strobes are present.

Verification
REQ-026 Single lane: N=M=2, write A lane0 values 3,5; load with A_start_en=01 on two cycles -> a_out lane0 shows 3 then 5, each one cycle after its load with a_valid=01; lane1 stays 0.
REQ-027 Skew: fill both A lanes with K=4 values; drive enables 01, 11, 11, 11, 10 on consecutive loads -> lane1 lags lane0 by exactly one load, and zeros with valid 0 appear where the enable is 0.
REQ-028 Full/overflow: write 5 values to A lane0 with K=4 -> the 5th is dropped and overflow=1; repeat with a same-cycle pop on the 5th write -> the write is accepted and overflow stays 0.
REQ-029 Finish: fill all lanes with K values, then drain all lanes -> finished=1 one cycle after the last pop; a new write -> finished=0 the following cycle.
REQ-030 Empty-pop and reset: a load on an empty lane with a simultaneous write of 9 -> output 0 with valid 0, and the next load outputs 9; assert rst=0 mid-drain -> outputs, counts, finished and overflow all go to 0 immediately, without waiting for a clk edge.
